// File: rtl/nibble_serial_cla_adder_if.sv
// Operand/result handshake bundle for nibble_serial_cla_adder.
// Optional macro SERIAL_ADD_SUB_EN adds the Sub control line.
// master = operand source / result consumer, slave = the adder.
interface nibble_serial_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             Sub;
`endif
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start_valid, A, B, Cin, Sub, done_ready,
        input  start_ready, done_valid, Sum, Cout, Ovf
    );
    modport slave (
        input  start_valid, A, B, Cin, Sub, done_ready,
        output start_ready, done_valid, Sum, Cout, Ovf
    );
`else
    modport master (
        output start_valid, A, B, Cin, done_ready,
        input  start_ready, done_valid, Sum, Cout, Ovf
    );
    modport slave (
        input  start_valid, A, B, Cin, done_ready,
        output start_ready, done_valid, Sum, Cout, Ovf
    );
`endif
endinterface

// File: rtl/nibble_serial_cla_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice per clock,
// carry rippled through a register between nibbles. NIB = WIDTH/4 cycles
// per operation. Optional macro SERIAL_ADD_SUB_EN enables A - B via Sub.
module nibble_serial_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_cla_adder_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_valid_q, done_valid_d;

    logic [3:0]       p, g, sum_nib;
    logic [4:0]       c;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // Operand B and initial carry as loaded at accept (inverted B and
    // forced carry-in of 1 turn the adder into a subtractor).
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_load     = bus.Sub ? ~bus.B : bus.B;
        carry_load = bus.Sub ? 1'b1   : bus.Cin;
    end
`else
    always_comb begin
        b_load     = bus.B;
        carry_load = bus.Cin;
    end
`endif

    // 4-bit lookahead carry cell on the low nibble of the operand shifters.
    always_comb begin
        p    = a_q[3:0] ^ b_q[3:0];
        g    = a_q[3:0] & b_q[3:0];
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum_nib = p ^ c[3:0];
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        done_valid_d = done_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.A;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = c[4];
                // New nibble enters at the MSB end so after NIB shifts
                // the first nibble processed sits at bits [3:0].
                sum_d   = (sum_q >> 4) | (WIDTH'(sum_nib) << (WIDTH - 4));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NIB - 1)) begin
                    cout_d       = c[4];
                    ovf_d        = c[4] ^ c[3];
                    done_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                done_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
            done_valid_q <= done_valid_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.done_valid  = done_valid_q;
    assign bus.Sum         = sum_q;
    assign bus.Cout        = cout_q;
    assign bus.Ovf         = ovf_q;
endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench for nibble_serial_cla_adder (WIDTH = 16).
// Expected {Ovf, Cout, Sum} are pushed when operands are driven and popped
// when done_valid is seen. Sub tests run when SERIAL_ADD_SUB_EN is defined.
module tb_nibble_serial_cla_adder;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [WIDTH+1:0] exp_q[$];

    nibble_serial_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin,
                                               input logic sub);
        logic [WIDTH-1:0] bb;
        logic             ci;
        logic [WIDTH:0]   full;
        logic             ovf;
        bb   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
        ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    // Drive one accept starting at a negedge while the DUT is idle;
    // returns at the negedge after the accept edge.
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub);
        bus.A           = a;
        bus.B           = b;
        bus.Cin         = cin;
`ifdef SERIAL_ADD_SUB_EN
        bus.Sub         = sub;
        exp_q.push_back(model(a, b, cin, sub));
`else
        exp_q.push_back(model(a, b, cin, 1'b0));
`endif
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
    endtask

    // Counts negedges until done_valid; -1 if the bound expires.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done_valid) cyc = -1;
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b0;
        bus.A           = '0;
        bus.B           = '0;
        bus.Cin         = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.Sub         = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.start_ready, bus.done_valid, bus.Cout, bus.Ovf, bus.Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state: rdy=%b dv=%b cout=%b ovf=%b sum=%h required rdy=1 dv=0 cout=0 ovf=0 sum=0000",
                     bus.start_ready, bus.done_valid, bus.Cout, bus.Ovf, bus.Sum);
        end
        $display("reset: rdy=%b dv=%b sum=%h", bus.start_ready, bus.done_valid, bus.Sum);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] ta [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [WIDTH-1:0] tb [3] = '{16'h4321, 16'h0001, 16'h0000};
        logic             tc [3] = '{1'b0, 1'b0, 1'b1};
        logic [WIDTH+1:0] e;
        int cyc;
        bus.done_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_start(ta[i], tb[i], tc[i], 1'b0);
            wait_done(cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc != 4) begin
                failures++;
                $display("FAIL latency_%0d: got %0d cycles required 4", i, cyc);
            end
            checks++;
            if ({bus.Ovf, bus.Cout, bus.Sum} !== e) begin
                failures++;
                $display("FAIL directed_%0d: ovf/cout/sum=%b/%b/%h required %b/%b/%h",
                         i, bus.Ovf, bus.Cout, bus.Sum, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
            end
            $display("directed %h+%h+%b -> sum=%h cout=%b ovf=%b lat=%0d",
                     ta[i], tb[i], tc[i], bus.Sum, bus.Cout, bus.Ovf, cyc);
            @(negedge clk);
            checks++;
            if (bus.start_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_%0d: rdy=%b dv=%b required rdy=1 dv=0",
                         i, bus.start_ready, bus.done_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [WIDTH+1:0] e;
        logic [WIDTH-1:0] held_sum;
        int cyc;
        bus.done_ready = 1'b0;
        drive_start(16'hA5A5, 16'h1111, 1'b1, 1'b0);
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc < 0 || {bus.Ovf, bus.Cout, bus.Sum} !== e) begin
            failures++;
            $display("FAIL bp_result: cyc=%0d sum=%h required sum=%h", cyc, bus.Sum, e[WIDTH-1:0]);
        end
        held_sum = bus.Sum;
        for (int k = 0; k < 3; k++) begin
            bus.start_valid = (k == 1);
            bus.A = 16'h0F0F;
            bus.B = 16'h0101;
            @(negedge clk);
            checks++;
            if (bus.done_valid !== 1'b1 || bus.start_ready !== 1'b0 ||
                {bus.Ovf, bus.Cout, bus.Sum} !== e || bus.Sum !== held_sum) begin
                failures++;
                $display("FAIL bp_hold_%0d: dv=%b rdy=%b sum=%h required dv=1 rdy=0 sum=%h",
                         k, bus.done_valid, bus.start_ready, bus.Sum, e[WIDTH-1:0]);
            end
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.start_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rdy=%b dv=%b required rdy=1 dv=0", bus.start_ready, bus.done_valid);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.done_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_ghost: dv=%b rdy=%b required dv=0 rdy=1", bus.done_valid, bus.start_ready);
        end
        $display("backpressure: held sum=%h released ok", held_sum);
    endtask

    task automatic test_reset_mid_run;
        logic [WIDTH+1:0] e;
        int cyc;
        bus.done_ready = 1'b1;
        drive_start(16'h1357, 16'h2468, 1'b0, 1'b0);
        @(negedge clk);               // now in second RUN cycle
        rst_n = 1'b0;
        void'(exp_q.pop_front());     // result discarded by reset
        #1;
        checks++;
        if ({bus.start_ready, bus.done_valid, bus.Cout, bus.Ovf, bus.Sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL reset_mid_run: rdy=%b dv=%b cout=%b ovf=%b sum=%h required 1/0/0/0/0000",
                     bus.start_ready, bus.done_valid, bus.Cout, bus.Ovf, bus.Sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.done_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard: dv=%b required 0", bus.done_valid);
        end
        drive_start(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 4 || {bus.Ovf, bus.Cout, bus.Sum} !== e || bus.Sum !== 16'h0100) begin
            failures++;
            $display("FAIL after_reset_op: cyc=%0d sum=%h required cyc=4 sum=0100", cyc, bus.Sum);
        end
        $display("reset mid-run: following op sum=%h", bus.Sum);
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub;
        logic [WIDTH-1:0] ta [2] = '{16'h0005, 16'h8000};
        logic [WIDTH-1:0] tb [2] = '{16'h0007, 16'h0001};
        logic [WIDTH+1:0] req [2] = '{{1'b0, 1'b0, 16'hFFFE}, {1'b1, 1'b1, 16'h7FFF}};
        logic [WIDTH+1:0] e;
        int cyc;
        bus.done_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_start(ta[i], tb[i], 1'b0, 1'b1);
            wait_done(cyc);
            e = exp_q.pop_front();
            checks++;
            if ({bus.Ovf, bus.Cout, bus.Sum} !== e || e !== req[i]) begin
                failures++;
                $display("FAIL sub_%0d: ovf/cout/sum=%b/%b/%h required %b/%b/%h", i,
                         bus.Ovf, bus.Cout, bus.Sum, req[i][WIDTH+1], req[i][WIDTH], req[i][WIDTH-1:0]);
            end
            $display("sub %h-%h -> sum=%h cout=%b ovf=%b", ta[i], tb[i], bus.Sum, bus.Cout, bus.Ovf);
            @(negedge clk);
        end
        bus.Sub = 1'b0;
    endtask
`endif

    task automatic test_back_to_back;
        logic [WIDTH-1:0] a, b;
        logic             cin, sub;
        logic [WIDTH+1:0] e;
        int cyc;
        int bad;
        bad = 0;
        bus.done_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; end
            if (i == 1) begin a = 16'h8000; b = 16'h8000; cin = 1'b0; end
            drive_start(a, b, cin, sub);
            wait_done(cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc != 4 || {bus.Ovf, bus.Cout, bus.Sum} !== e) begin
                failures++;
                bad++;
                $display("FAIL b2b_%0d: a=%h b=%h cin=%b sub=%b cyc=%0d got %b/%b/%h required %b/%b/%h",
                         i, a, b, cin, sub, cyc, bus.Ovf, bus.Cout, bus.Sum,
                         e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
            end
            if (i < 4)
                $display("b2b %0d: %h %h %b sub=%b -> sum=%h cout=%b ovf=%b",
                         i, a, b, cin, sub, bus.Sum, bus.Cout, bus.Ovf);
            if (cyc < 0) break;
            @(negedge clk);
        end
        $display("back-to-back: 1000 ops, %0d mismatched", bad);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
